// File: rtl/mips_core_pkg.sv
// Shared mips_core back-end types.
// Issue-queue entry layout and default widths.
package mips_core_pkg;

  localparam int IQ_TAG_W     = 6;
  localparam int IQ_PAYLOAD_W = 32;

  typedef struct packed {
    logic                    valid;
    logic [IQ_TAG_W-1:0]     dst;
    logic [IQ_TAG_W-1:0]     src1;
    logic [IQ_TAG_W-1:0]     src2;
    logic                    rdy1;
    logic                    rdy2;
    logic [IQ_PAYLOAD_W-1:0] payload;
  } iq_entry_t;

endpackage

// File: rtl/priority_encoder.sv
// One-hot-free priority encoder over a request vector.
// Output is meaningless when no request bit is set.
module priority_encoder #(
  parameter int NUM_OF_INPUTS = 8,
  parameter int HIGH_PRIORITY = 0
) (
  input  logic [NUM_OF_INPUTS-1:0]         i_req,
  output logic [$clog2(NUM_OF_INPUTS)-1:0] o_idx
);

  localparam int IDX_W = $clog2(NUM_OF_INPUTS);

  // The last hit in loop order wins, so iterate toward the favoured end.
  always_comb begin
    o_idx = '0;
    if (HIGH_PRIORITY == 0) begin
      for (int i = NUM_OF_INPUTS - 1; i >= 0; i--) begin
        if (i_req[i]) o_idx = IDX_W'(i);
      end
    end else begin
      for (int i = 0; i < NUM_OF_INPUTS; i++) begin
        if (i_req[i]) o_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/issue_queue.sv
// Out-of-order issue queue with CDB wakeup and lowest-index select.
// Entry fields use the widths fixed in mips_core_pkg.
module issue_queue
  import mips_core_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int TAG_W     = IQ_TAG_W,
  parameter int PAYLOAD_W = IQ_PAYLOAD_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         dispatch_valid,
  output logic                         dispatch_ready,
  input  logic [TAG_W-1:0]             dispatch_dst,
  input  logic [TAG_W-1:0]             dispatch_src1,
  input  logic [TAG_W-1:0]             dispatch_src2,
  input  logic                         dispatch_src1_rdy,
  input  logic                         dispatch_src2_rdy,
  input  logic [PAYLOAD_W-1:0]         dispatch_payload,
  input  logic                         cdb_valid,
  input  logic [TAG_W-1:0]             cdb_tag,
  output logic                         issue_valid,
  input  logic                         issue_ready,
  output logic [TAG_W-1:0]             issue_dst,
  output logic [PAYLOAD_W-1:0]         issue_payload,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);

  iq_entry_t        r_q     [DEPTH];
  iq_entry_t        w_q_nxt [DEPTH];
  logic [OCC_W-1:0] r_occ;
  logic [OCC_W-1:0] w_occ_nxt;
  logic [DEPTH-1:0] w_free;
  logic [DEPTH-1:0] w_req;
  logic [IDX_W-1:0] w_alloc;
  logic [IDX_W-1:0] w_sel;
  logic             w_disp_fire;
  logic             w_iss_fire;
  logic             w_s1_hit;
  logic             w_s2_hit;

  always_comb begin
    w_free = '0;
    w_req  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_free[i] = ~r_q[i].valid;
      w_req[i]  = r_q[i].valid & r_q[i].rdy1 & r_q[i].rdy2;
    end
  end

  priority_encoder #(
    .NUM_OF_INPUTS (DEPTH),
    .HIGH_PRIORITY (0)
  ) u_alloc_enc (
    .i_req (w_free),
    .o_idx (w_alloc)
  );

  priority_encoder #(
    .NUM_OF_INPUTS (DEPTH),
    .HIGH_PRIORITY (0)
  ) u_sel_enc (
    .i_req (w_req),
    .o_idx (w_sel)
  );

  assign dispatch_ready = (|w_free) & ~flush;
  assign issue_valid    = (|w_req) & ~flush;
  assign w_disp_fire    = dispatch_valid & dispatch_ready;
  assign w_iss_fire     = issue_valid & issue_ready;

  assign issue_dst     = r_q[w_sel].dst;
  assign issue_payload = r_q[w_sel].payload;
  assign occupancy     = r_occ;

  // A tag on the CDB this cycle also wakes the op being written now.
  assign w_s1_hit = cdb_valid & (cdb_tag == dispatch_src1);
  assign w_s2_hit = cdb_valid & (cdb_tag == dispatch_src2);

  always_comb begin
    w_q_nxt = r_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_q[i].valid & cdb_valid) begin
        if (cdb_tag == r_q[i].src1) w_q_nxt[i].rdy1 = 1'b1;
        if (cdb_tag == r_q[i].src2) w_q_nxt[i].rdy2 = 1'b1;
      end
    end
    if (w_iss_fire) w_q_nxt[w_sel].valid = 1'b0;
    if (w_disp_fire) begin
      w_q_nxt[w_alloc].valid   = 1'b1;
      w_q_nxt[w_alloc].dst     = dispatch_dst;
      w_q_nxt[w_alloc].src1    = dispatch_src1;
      w_q_nxt[w_alloc].src2    = dispatch_src2;
      w_q_nxt[w_alloc].rdy1    = dispatch_src1_rdy | w_s1_hit;
      w_q_nxt[w_alloc].rdy2    = dispatch_src2_rdy | w_s2_hit;
      w_q_nxt[w_alloc].payload = dispatch_payload;
    end
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) w_q_nxt[i].valid = 1'b0;
    end
  end

  always_comb begin
    if (flush) w_occ_nxt = '0;
    else w_occ_nxt = r_occ + OCC_W'(w_disp_fire) - OCC_W'(w_iss_fire);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_q[i].valid <= 1'b0;
        r_q[i].rdy1  <= 1'b0;
        r_q[i].rdy2  <= 1'b0;
      end
      r_occ <= '0;
    end else begin
      r_q   <= w_q_nxt;
      r_occ <= w_occ_nxt;
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench for issue_queue.
// Directed scenarios plus random traffic against a slot-level model.
module tb_issue_queue;

  localparam int DEPTH = 8;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        dispatch_valid;
  logic        dispatch_ready;
  logic [5:0]  dispatch_dst;
  logic [5:0]  dispatch_src1;
  logic [5:0]  dispatch_src2;
  logic        dispatch_src1_rdy;
  logic        dispatch_src2_rdy;
  logic [31:0] dispatch_payload;
  logic        cdb_valid;
  logic [5:0]  cdb_tag;
  logic        issue_valid;
  logic        issue_ready;
  logic [5:0]  issue_dst;
  logic [31:0] issue_payload;
  logic [3:0]  occupancy;

  int checks = 0;
  int errors = 0;

  issue_queue #(
    .DEPTH     (DEPTH),
    .TAG_W     (6),
    .PAYLOAD_W (32)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .flush             (flush),
    .dispatch_valid    (dispatch_valid),
    .dispatch_ready    (dispatch_ready),
    .dispatch_dst      (dispatch_dst),
    .dispatch_src1     (dispatch_src1),
    .dispatch_src2     (dispatch_src2),
    .dispatch_src1_rdy (dispatch_src1_rdy),
    .dispatch_src2_rdy (dispatch_src2_rdy),
    .dispatch_payload  (dispatch_payload),
    .cdb_valid         (cdb_valid),
    .cdb_tag           (cdb_tag),
    .issue_valid       (issue_valid),
    .issue_ready       (issue_ready),
    .issue_dst         (issue_dst),
    .issue_payload     (issue_payload),
    .occupancy         (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one record per slot, occupancy is a live count.
  bit          m_v  [DEPTH];
  bit          m_r1 [DEPTH];
  bit          m_r2 [DEPTH];
  logic [5:0]  m_dst[DEPTH];
  logic [5:0]  m_s1 [DEPTH];
  logic [5:0]  m_s2 [DEPTH];
  logic [31:0] m_pl [DEPTH];

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (m_v[i]) n++;
    return n;
  endfunction

  function automatic int m_sel();
    for (int i = 0; i < DEPTH; i++)
      if (m_v[i] && m_r1[i] && m_r2[i]) return i;
    return -1;
  endfunction

  function automatic int m_free();
    for (int i = 0; i < DEPTH; i++) if (!m_v[i]) return i;
    return -1;
  endfunction

  task automatic model_update();
    int  sel;
    int  slot;
    bit  dfire;
    bit  ifire;
    if (rst || flush) begin
      for (int i = 0; i < DEPTH; i++) m_v[i] = 0;
      return;
    end
    sel   = m_sel();
    slot  = m_free();
    dfire = dispatch_valid && (slot >= 0);
    ifire = issue_ready && (sel >= 0);
    for (int i = 0; i < DEPTH; i++) begin
      if (m_v[i] && cdb_valid && cdb_tag == m_s1[i]) m_r1[i] = 1;
      if (m_v[i] && cdb_valid && cdb_tag == m_s2[i]) m_r2[i] = 1;
    end
    if (ifire) m_v[sel] = 0;
    if (dfire) begin
      m_v[slot]   = 1;
      m_dst[slot] = dispatch_dst;
      m_s1[slot]  = dispatch_src1;
      m_s2[slot]  = dispatch_src2;
      m_pl[slot]  = dispatch_payload;
      m_r1[slot]  = dispatch_src1_rdy ||
                    (cdb_valid && cdb_tag == dispatch_src1);
      m_r2[slot]  = dispatch_src2_rdy ||
                    (cdb_valid && cdb_tag == dispatch_src2);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic set_idle();
    flush             = 0;
    dispatch_valid    = 0;
    dispatch_dst      = '0;
    dispatch_src1     = '0;
    dispatch_src2     = '0;
    dispatch_src1_rdy = 0;
    dispatch_src2_rdy = 0;
    dispatch_payload  = '0;
    cdb_valid         = 0;
    cdb_tag           = '0;
    issue_ready       = 0;
  endtask

  task automatic disp(input logic [5:0] d, input logic [5:0] s1,
                      input logic [5:0] s2, input bit r1, input bit r2,
                      input logic [31:0] pl);
    dispatch_valid    = 1;
    dispatch_dst      = d;
    dispatch_src1     = s1;
    dispatch_src2     = s2;
    dispatch_src1_rdy = r1;
    dispatch_src2_rdy = r2;
    dispatch_payload  = pl;
  endtask

  task automatic test_reset();
    rst = 1;
    set_idle();
    @(negedge clk);
    #1;
    checks++;
    if (dispatch_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_dready got %b exp 1", dispatch_ready);
    end
    checks++;
    if (issue_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ivalid got %b exp 0", issue_valid);
    end
    checks++;
    if (occupancy !== 4'd0) begin
      errors++;
      $display("FAIL reset_occ got %0d exp 0", occupancy);
    end
    tick();
    rst = 0;
    tick();
  endtask

  task automatic test_fill();
    for (int k = 0; k < DEPTH; k++) begin
      set_idle();
      disp(6'(10 + k), 6'd1, 6'd2, 1, 1, 32'hA000_0000 + k);
      #1;
      checks++;
      if (dispatch_ready !== 1'b1) begin
        errors++;
        $display("FAIL fill_dready k=%0d got %b exp 1", k, dispatch_ready);
      end
      if (k == 0) begin
        checks++;
        if (issue_valid !== 1'b0) begin
          errors++;
          $display("FAIL empty_ivalid got %b exp 0", issue_valid);
        end
      end
      tick();
    end
    set_idle();
    #1;
    checks++;
    if (dispatch_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_dready got %b exp 0", dispatch_ready);
    end
    checks++;
    if (occupancy !== 4'd8) begin
      errors++;
      $display("FAIL full_occ got %0d exp 8", occupancy);
    end
    checks++;
    if (issue_valid !== 1'b1 || issue_payload !== 32'hA000_0000 ||
        issue_dst !== 6'd10) begin
      errors++;
      $display("FAIL full_head got v=%b d=%0d p=%h exp v=1 d=10 p=a0000000",
               issue_valid, issue_dst, issue_payload);
    end
  endtask

  task automatic test_full_issue();
    set_idle();
    disp(6'd50, 6'd1, 6'd2, 1, 1, 32'hDEAD_0001);
    issue_ready = 1;
    #1;
    checks++;
    if (dispatch_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_iss_dready got %b exp 0", dispatch_ready);
    end
    tick();
    set_idle();
    #1;
    checks++;
    if (occupancy !== 4'd7) begin
      errors++;
      $display("FAIL full_iss_occ got %0d exp 7", occupancy);
    end
    checks++;
    if (issue_payload !== 32'hA000_0001) begin
      errors++;
      $display("FAIL full_iss_next got %h exp a0000001", issue_payload);
    end
  endtask

  task automatic test_flush();
    set_idle();
    issue_ready = 1;
    tick();
    tick();
    set_idle();
    #1;
    checks++;
    if (occupancy !== 4'd5) begin
      errors++;
      $display("FAIL pre_flush_occ got %0d exp 5", occupancy);
    end
    flush = 1;
    disp(6'd60, 6'd1, 6'd2, 1, 1, 32'hF00D_0000);
    issue_ready = 1;
    #1;
    checks++;
    if (dispatch_ready !== 1'b0 || issue_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_outs got dr=%b iv=%b exp dr=0 iv=0",
               dispatch_ready, issue_valid);
    end
    tick();
    set_idle();
    #1;
    checks++;
    if (occupancy !== 4'd0 || issue_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_flush got occ=%0d iv=%b exp occ=0 iv=0",
               occupancy, issue_valid);
    end
    tick();
    #1;
    checks++;
    if (occupancy !== 4'd0 || issue_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_drop got occ=%0d iv=%b exp occ=0 iv=0",
               occupancy, issue_valid);
    end
  endtask

  task automatic test_wakeup();
    set_idle();
    disp(6'd33, 6'd5, 6'd7, 0, 1, 32'h0000_0033);
    tick();
    set_idle();
    #1;
    checks++;
    if (issue_valid !== 1'b0) begin
      errors++;
      $display("FAIL wake_wait got %b exp 0", issue_valid);
    end
    tick();
    cdb_valid = 1;
    cdb_tag   = 6'd5;
    #1;
    checks++;
    if (issue_valid !== 1'b0) begin
      errors++;
      $display("FAIL wake_bypass got %b exp 0", issue_valid);
    end
    tick();
    set_idle();
    #1;
    checks++;
    if (issue_valid !== 1'b1 || issue_dst !== 6'd33) begin
      errors++;
      $display("FAIL wake_issue got v=%b d=%0d exp v=1 d=33",
               issue_valid, issue_dst);
    end
    issue_ready = 1;
    tick();
    set_idle();
    #1;
    checks++;
    if (occupancy !== 4'd0) begin
      errors++;
      $display("FAIL wake_drain got %0d exp 0", occupancy);
    end
  endtask

  task automatic test_same_cycle_wakeup();
    set_idle();
    disp(6'd44, 6'd3, 6'd9, 1, 0, 32'h0000_0044);
    cdb_valid = 1;
    cdb_tag   = 6'd9;
    #1;
    checks++;
    if (issue_valid !== 1'b0) begin
      errors++;
      $display("FAIL same_cyc_now got %b exp 0", issue_valid);
    end
    tick();
    set_idle();
    #1;
    checks++;
    if (issue_valid !== 1'b1 || issue_dst !== 6'd44) begin
      errors++;
      $display("FAIL same_cyc_next got v=%b d=%0d exp v=1 d=44",
               issue_valid, issue_dst);
    end
    issue_ready = 1;
    tick();
    set_idle();
  endtask

  task automatic test_priority();
    set_idle();
    disp(6'd20, 6'd20, 6'd20, 0, 0, 32'h70); tick();
    disp(6'd21, 6'd1,  6'd1,  1, 1, 32'h71); tick();
    disp(6'd22, 6'd21, 6'd21, 0, 0, 32'h72); tick();
    disp(6'd23, 6'd2,  6'd2,  1, 1, 32'h73); tick();
    set_idle();
    issue_ready = 1;
    #1;
    checks++;
    if (issue_valid !== 1'b1 || issue_dst !== 6'd21) begin
      errors++;
      $display("FAIL prio_first got v=%b d=%0d exp v=1 d=21",
               issue_valid, issue_dst);
    end
    tick();
    #1;
    checks++;
    if (issue_valid !== 1'b1 || issue_dst !== 6'd23) begin
      errors++;
      $display("FAIL prio_second got v=%b d=%0d exp v=1 d=23",
               issue_valid, issue_dst);
    end
    tick();
    set_idle();
    #1;
    checks++;
    if (issue_valid !== 1'b0 || occupancy !== 4'd2) begin
      errors++;
      $display("FAIL prio_rest got v=%b occ=%0d exp v=0 occ=2",
               issue_valid, occupancy);
    end
    flush = 1;
    tick();
    set_idle();
  endtask

  task automatic test_random();
    bit exp_dr;
    bit exp_iv;
    int sel;
    for (int c = 0; c < 3000; c++) begin
      set_idle();
      flush          = ($urandom_range(0, 63) == 0);
      dispatch_valid = ($urandom_range(0, 9) < 6);
      disp_fields: begin
        dispatch_dst      = 6'($urandom_range(0, 63));
        dispatch_src1     = 6'($urandom_range(0, 7));
        dispatch_src2     = 6'($urandom_range(0, 7));
        dispatch_src1_rdy = $urandom_range(0, 1) == 1;
        dispatch_src2_rdy = $urandom_range(0, 1) == 1;
        dispatch_payload  = $urandom;
      end
      cdb_valid   = $urandom_range(0, 1) == 1;
      cdb_tag     = 6'($urandom_range(0, 7));
      issue_ready = $urandom_range(0, 1) == 1;
      #1;
      sel    = m_sel();
      exp_dr = !flush && (m_count() < DEPTH);
      exp_iv = !flush && (sel >= 0);
      checks++;
      if (dispatch_ready !== exp_dr) begin
        errors++;
        $display("FAIL rnd_dready cyc=%0d got %b exp %b",
                 c, dispatch_ready, exp_dr);
      end
      checks++;
      if (issue_valid !== exp_iv) begin
        errors++;
        $display("FAIL rnd_ivalid cyc=%0d got %b exp %b",
                 c, issue_valid, exp_iv);
      end
      checks++;
      if (occupancy !== 4'(m_count())) begin
        errors++;
        $display("FAIL rnd_occ cyc=%0d got %0d exp %0d",
                 c, occupancy, m_count());
      end
      if (exp_iv) begin
        checks++;
        if (issue_dst !== m_dst[sel] || issue_payload !== m_pl[sel]) begin
          errors++;
          $display("FAIL rnd_entry cyc=%0d got d=%0d p=%h exp d=%0d p=%h",
                   c, issue_dst, issue_payload, m_dst[sel], m_pl[sel]);
        end
      end
      tick();
    end
    set_idle();
    flush = 1;
    tick();
    set_idle();
  endtask

  task automatic test_async_reset();
    set_idle();
    for (int k = 0; k < 3; k++) begin
      disp(6'(k), 6'd1, 6'd2, 1, 1, 32'hB000_0000 + k);
      tick();
    end
    set_idle();
    #1;
    checks++;
    if (occupancy !== 4'd3 || issue_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_rst got occ=%0d iv=%b exp occ=3 iv=1",
               occupancy, issue_valid);
    end
    #1;
    rst = 1;
    #1;
    checks++;
    if (occupancy !== 4'd0 || issue_valid !== 1'b0 ||
        dispatch_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_rst got occ=%0d iv=%b dr=%b exp 0 0 1",
               occupancy, issue_valid, dispatch_ready);
    end
    tick();
    rst = 0;
    #1;
    checks++;
    if (occupancy !== 4'd0 || issue_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_rst got occ=%0d iv=%b exp 0 0",
               occupancy, issue_valid);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_issue();
    test_flush();
    test_wakeup();
    test_same_cycle_wakeup();
    test_priority();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
